// File: rtl/fwd_pkg.sv
// Shared types and encodings for the forwarding/hazard scoreboard.
// Latency: n/a (types only).
// Backpressure: n/a.
//
// Slot fields are sized to fixed maxima so one typedef serves every
// parameterisation; the scoreboard zero-extends narrower indices into them
// and synthesis trims the constant upper bits. REG_W and SEL_W must not exceed
// SB_IDX_MAX_W and SB_RDY_MAX_W respectively.
package fwd_pkg;

  localparam int SB_IDX_MAX_W = 8;
  localparam int SB_RDY_MAX_W = 8;

  // Forwarding select encodings (slot index the operand is taken from).
  localparam int FWD_RF  = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

  // Producer latency classes: first slot in which the result is forwardable.
  localparam int RDY_ALU  = 1;
  localparam int RDY_LOAD = 2;

  typedef struct packed {
    logic                    valid;
    logic [SB_IDX_MAX_W-1:0] rd;
    logic [SB_RDY_MAX_W-1:0] rdy;
  } slot_t;

  // A ready class of 0 is meaningless, so it is promoted to the ALU class.
  function automatic logic [SB_RDY_MAX_W-1:0] norm_rdy(input logic [SB_RDY_MAX_W-1:0] r);
    return (r == '0) ? SB_RDY_MAX_W'(RDY_ALU) : r;
  endfunction

endpackage

// File: rtl/fwd_port_check.sv
// Per-source-port priority comparator across all scoreboard slots.
// Latency: purely combinational.
// Backpressure: none; hazard_o feeds the stall OR in the parent.
//
// Ports:
//   slots_i  : current slot contents, index 0 = EX (youngest)
//   chk_en_i : port is valid, used and not x0
//   rs_i     : source register index
//   hazard_o : producer result not forwardable in time
//   sel_o    : forwarding select for the next cycle (0 = register file)
module fwd_port_check
  import fwd_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int NSTG  = 3,
  parameter int SEL_W = $clog2(NSTG)
) (
  input  slot_t [NSTG-1:0] slots_i,
  input  logic             chk_en_i,
  input  logic [REG_W-1:0] rs_i,
  output logic             hazard_o,
  output logic [SEL_W-1:0] sel_o
);

  // Scan oldest to youngest so the youngest matching writer overrides
  // everything older; older matches never influence the result.
  always_comb begin
    hazard_o = 1'b0;
    sel_o    = SEL_W'(FWD_RF);
    for (int s = NSTG - 1; s >= 0; s--) begin
      if (chk_en_i && slots_i[s].valid && (slots_i[s].rd == SB_IDX_MAX_W'(rs_i))) begin
        if (s == NSTG - 1) begin
          // Retiring this cycle: the write-through register file supplies it.
          hazard_o = 1'b0;
          sel_o    = SEL_W'(FWD_RF);
        end else if ((s + 1) < int'(slots_i[s].rdy)) begin
          hazard_o = 1'b1;
          sel_o    = SEL_W'(FWD_RF);
        end else begin
          // Next cycle the producer sits one slot further down.
          hazard_o = 1'b0;
          sel_o    = SEL_W'(s + 1);
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Producer-latency-aware scoreboard: stalls ID on unready operands, else picks EX forwarding.
// Latency: stall_o combinational in the ID cycle; ex_fwd_sel_o registered, valid in the EX cycle.
// Backpressure: stall_o holds IF/ID and injects a bubble; flush_i overrides any stall.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   id_valid_i          : ID holds a real instruction
//   id_rs_i/id_rs_used_i: NRD source indices and their use flags
//   id_wr_i/id_rd_i     : destination write enable and index
//   id_rdy_i            : first slot where the result is forwardable (0 treated as 1)
//   flush_i             : squash the ID instruction this cycle
//   stall_o             : hold IF/ID, bubble into EX
//   ex_fwd_sel_o        : per-port select for the instruction in EX
//   sb_busy_o           : any slot valid
// Optional build macro FWD_PERF_CNT_EN adds perf_stall_o, perf_fwd_o, perf_flush_o
// (32-bit wrapping event counters cleared by reset).
module fwd_hazard_scoreboard
  import fwd_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int NRD   = 2,
  parameter int NSTG  = 3,
  parameter int SEL_W = $clog2(NSTG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid_i,
  input  logic [NRD*REG_W-1:0] id_rs_i,
  input  logic [NRD-1:0]       id_rs_used_i,
  input  logic                 id_wr_i,
  input  logic [REG_W-1:0]     id_rd_i,
  input  logic [SEL_W-1:0]     id_rdy_i,
  input  logic                 flush_i,
  output logic                 stall_o,
  output logic [NRD*SEL_W-1:0] ex_fwd_sel_o,
  output logic                 sb_busy_o
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]          perf_stall_o,
  output logic [31:0]          perf_fwd_o,
  output logic [31:0]          perf_flush_o
`endif
);

  slot_t [NSTG-1:0]     slot_q, slot_d;
  logic [NRD*SEL_W-1:0] fwd_sel_q, fwd_sel_d;
  logic [NRD*SEL_W-1:0] port_sel;
  logic [NRD-1:0]       port_hz;
  logic [NRD-1:0]       port_en;
  logic                 advance;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    assign port_en[p] = id_valid_i & id_rs_used_i[p] & (id_rs_i[p*REG_W +: REG_W] != '0);

    fwd_port_check #(
      .REG_W (REG_W),
      .NSTG  (NSTG),
      .SEL_W (SEL_W)
    ) u_chk (
      .slots_i  (slot_q),
      .chk_en_i (port_en[p]),
      .rs_i     (id_rs_i[p*REG_W +: REG_W]),
      .hazard_o (port_hz[p]),
      .sel_o    (port_sel[p*SEL_W +: SEL_W])
    );
  end

  // Flush squashes the ID instruction, so it never needs to wait.
  assign stall_o = (|port_hz) & ~flush_i;
  assign advance = id_valid_i & ~stall_o & ~flush_i;

  always_comb begin
    slot_d = '0;
    if (advance) begin
      // x0 writers are never tracked: reads of x0 are constant.
      slot_d[0].valid = id_wr_i & (id_rd_i != '0);
      slot_d[0].rd    = SB_IDX_MAX_W'(id_rd_i);
      slot_d[0].rdy   = norm_rdy(SB_RDY_MAX_W'(id_rdy_i));
    end
    for (int i = 1; i < NSTG; i++) begin
      slot_d[i] = slot_q[i-1];
    end
  end

  // Anything that does not advance leaves a bubble in EX, which uses the RF path.
  always_comb begin
    fwd_sel_d = advance ? port_sel : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q    <= '0;
      fwd_sel_q <= '0;
    end else begin
      slot_q    <= slot_d;
      fwd_sel_q <= fwd_sel_d;
    end
  end

  assign ex_fwd_sel_o = fwd_sel_q;

  always_comb begin
    sb_busy_o = 1'b0;
    for (int i = 0; i < NSTG; i++) begin
      sb_busy_o = sb_busy_o | slot_q[i].valid;
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_fwd_q, perf_fwd_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, stall_o};
    perf_fwd_d   = perf_fwd_q + {31'd0, advance & (|port_sel)};
    perf_flush_d = perf_flush_q + {31'd0, flush_i};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_fwd_q   <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_fwd_q   <= perf_fwd_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_o = perf_stall_q;
  assign perf_fwd_o   = perf_fwd_q;
  assign perf_flush_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Self-checking bench for fwd_hazard_scoreboard: directed scenarios plus random traffic,
// compared against a queue-of-producers reference model tracking each writer's age.
module tb_fwd_hazard_scoreboard;

  localparam int REG_W = 5;
  localparam int NRD   = 2;
  localparam int NSTG  = 3;
  localparam int SEL_W = 2;

  logic                 clk;
  logic                 reset;
  logic                 id_valid_i;
  logic [NRD*REG_W-1:0] id_rs_i;
  logic [NRD-1:0]       id_rs_used_i;
  logic                 id_wr_i;
  logic [REG_W-1:0]     id_rd_i;
  logic [SEL_W-1:0]     id_rdy_i;
  logic                 flush_i;
  logic                 stall_o;
  logic [NRD*SEL_W-1:0] ex_fwd_sel_o;
  logic                 sb_busy_o;
`ifdef FWD_PERF_CNT_EN
  logic [31:0]          perf_stall_o, perf_fwd_o, perf_flush_o;
`endif

  fwd_hazard_scoreboard #(
    .REG_W (REG_W),
    .NRD   (NRD),
    .NSTG  (NSTG),
    .SEL_W (SEL_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid_i   (id_valid_i),
    .id_rs_i      (id_rs_i),
    .id_rs_used_i (id_rs_used_i),
    .id_wr_i      (id_wr_i),
    .id_rd_i      (id_rd_i),
    .id_rdy_i     (id_rdy_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .ex_fwd_sel_o (ex_fwd_sel_o),
    .sb_busy_o    (sb_busy_o)
`ifdef FWD_PERF_CNT_EN
    ,
    .perf_stall_o (perf_stall_o),
    .perf_fwd_o   (perf_fwd_o),
    .perf_flush_o (perf_flush_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: every in-flight writer with its age in cycles since it
  // left ID (age 0 = in EX). Queue is kept youngest-first.
  typedef struct {
    int rd;
    int rdy;
    int age;
  } prod_t;

  prod_t                q[$];
  logic [NRD*SEL_W-1:0] exp_ex_sel;
  logic                 last_stall;
  int                   n_tests;
  int                   n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input int rs0, input int rs1, input logic [1:0] used,
                        input logic wr, input int rd, input int rdy, input logic fl);
    id_valid_i   = v;
    id_rs_i      = {REG_W'(rs1), REG_W'(rs0)};
    id_rs_used_i = used;
    id_wr_i      = wr;
    id_rd_i      = REG_W'(rd);
    id_rdy_i     = SEL_W'(rdy);
    flush_i      = fl;
  endtask

  // One cycle: predict outputs from the model, compare, clock, advance the model.
  task automatic tick();
    logic [NRD-1:0]       hz;
    logic [NRD*SEL_W-1:0] sels;
    logic                 m_stall;
    logic                 m_adv;
    int                   rsv;
    int                   a;
    int                   rdy_eff;
    #1;
    hz   = '0;
    sels = '0;
    for (int p = 0; p < NRD; p++) begin
      rsv = int'(id_rs_i[p*REG_W +: REG_W]);
      if (id_valid_i && id_rs_used_i[p] && rsv != 0) begin
        for (int k = 0; k < q.size(); k++) begin
          if (q[k].rd == rsv) begin
            a = q[k].age;
            if (a == NSTG - 1)      sels[p*SEL_W +: SEL_W] = '0;
            else if (a + 1 < q[k].rdy) hz[p] = 1'b1;
            else                    sels[p*SEL_W +: SEL_W] = SEL_W'(a + 1);
            break;
          end
        end
      end
    end
    m_stall = (|hz) && !flush_i;
    m_adv   = id_valid_i && !m_stall && !flush_i;
    check("stall", 32'(stall_o), 32'(m_stall));
    check("busy", 32'(sb_busy_o), 32'(q.size() != 0));
    check("ex_sel", 32'(ex_fwd_sel_o), 32'(exp_ex_sel));
    last_stall = stall_o;
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      exp_ex_sel = '0;
    end else begin
      for (int k = 0; k < q.size(); k++) q[k].age++;
      while (q.size() > 0 && q[q.size()-1].age > NSTG - 1) void'(q.pop_back());
      if (m_adv && id_wr_i && id_rd_i != '0) begin
        rdy_eff = (id_rdy_i == '0) ? 1 : int'(id_rdy_i);
        q.push_front('{rd: int'(id_rd_i), rdy: rdy_eff, age: 0});
      end
      exp_ex_sel = m_adv ? sels : '0;
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    last_stall = 1'b0;
    exp_ex_sel = '0;
    reset      = 1'b1;
    set_id(1'b0, 0, 0, 2'b00, 1'b0, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_busy", 32'(sb_busy_o), 32'd0);
    check("rst_sel", 32'(ex_fwd_sel_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);

    // ALU chain: add x5 then consumer of x5 on port 0.
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 5, 1, 1'b0); tick();
    set_id(1'b1, 5, 0, 2'b01, 1'b0, 0, 0, 1'b0); tick();
    check("alu_stall", 32'(last_stall), 32'd0);
    check("alu_sel_p0", 32'(ex_fwd_sel_o[1:0]), 32'd1);

    // Load-use on port 1: one stall cycle, then forward from slot 2.
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 7, 2, 1'b0); tick();
    set_id(1'b1, 0, 7, 2'b10, 1'b0, 0, 0, 1'b0); tick();
    check("lu_stall", 32'(last_stall), 32'd1);
    check("lu_bubble_sel", 32'(ex_fwd_sel_o), 32'd0);
    tick();
    check("lu_release", 32'(last_stall), 32'd0);
    check("lu_sel_p1", 32'(ex_fwd_sel_o[3:2]), 32'd2);

    // Priority: two back-to-back writers of x3, youngest wins.
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 3, 1, 1'b0); tick();
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 3, 1, 1'b0); tick();
    set_id(1'b1, 3, 0, 2'b01, 1'b0, 0, 0, 1'b0); tick();
    check("prio_stall", 32'(last_stall), 32'd0);
    check("prio_sel_p0", 32'(ex_fwd_sel_o[1:0]), 32'd1);

    // x0 writer and reader of x0.
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 0, 2, 1'b0); tick();
    set_id(1'b1, 0, 0, 2'b01, 1'b0, 0, 0, 1'b0); tick();
    check("x0_stall", 32'(last_stall), 32'd0);
    check("x0_sel", 32'(ex_fwd_sel_o), 32'd0);

    // Unused ports against a live load match.
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 9, 2, 1'b0); tick();
    set_id(1'b1, 9, 9, 2'b00, 1'b0, 0, 0, 1'b0); tick();
    check("unused_stall", 32'(last_stall), 32'd0);
    check("unused_sel", 32'(ex_fwd_sel_o), 32'd0);

    // Flush during a load-use hazard.
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 7, 2, 1'b0); tick();
    set_id(1'b1, 0, 7, 2'b10, 1'b0, 0, 0, 1'b1); tick();
    check("flush_stall", 32'(last_stall), 32'd0);
    check("flush_sel", 32'(ex_fwd_sel_o), 32'd0);

    // Ready class beyond the last forwarding slot: stall until retirement, then RF.
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 4, 3, 1'b0); tick();
    set_id(1'b1, 4, 0, 2'b01, 1'b0, 0, 0, 1'b0); tick();
    check("late_stall0", 32'(last_stall), 32'd1);
    tick();
    check("late_stall1", 32'(last_stall), 32'd1);
    tick();
    check("late_release", 32'(last_stall), 32'd0);
    check("late_sel", 32'(ex_fwd_sel_o), 32'd0);

    // Ready class 0 behaves as ALU.
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 6, 0, 1'b0); tick();
    set_id(1'b1, 6, 0, 2'b01, 1'b0, 0, 0, 1'b0); tick();
    check("rdy0_stall", 32'(last_stall), 32'd0);
    check("rdy0_sel", 32'(ex_fwd_sel_o[1:0]), 32'd1);

    // Reset mid-stream with all slots occupied.
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 10, 1, 1'b0); tick();
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 11, 2, 1'b0); tick();
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 12, 2, 1'b0); tick();
    check("pre_rst_busy", 32'(sb_busy_o), 32'd1);
    set_id(1'b0, 0, 0, 2'b00, 1'b0, 0, 0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", 32'(sb_busy_o), 32'd0);
    check("mid_rst_sel", 32'(ex_fwd_sel_o), 32'd0);
    set_id(1'b1, 12, 11, 2'b11, 1'b0, 0, 0, 1'b0); tick();
    check("post_rst_stall", 32'(last_stall), 32'd0);
    check("post_rst_sel", 32'(ex_fwd_sel_o), 32'd0);

    // Random traffic on a small register range to provoke frequent matches.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      set_id(($urandom_range(0, 9) < 8), $urandom_range(0, 7), $urandom_range(0, 7),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
             $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
      tick();
    end
    reset = 1'b0;
    set_id(1'b0, 0, 0, 2'b00, 1'b0, 0, 0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
- Parametrised successor to the pipeline forwarding unit. Tracks in-flight register writers in an internal slot shift-register: slot 0 = EX, slot 1 = MEM, ..., slot NSTG-1 = WB.
- For each of NRD source ports of the instruction in ID, it either raises a load-use/latency stall or computes a forwarding select. The select is registered so it is aligned with the instruction's EX cycle.
- Sits between the decoder/ID stage and the EX operand muxes. It replaces ad-hoc pipeline-register comparisons with a producer-latency-aware scoreboard.

Parameters:
- REG_W, 5, register index width.
- NRD, 2, number of source-operand ports checked per instruction.
- NSTG, 3, number of tracked slots after ID (EX..WB); must be >= 2.
- SEL_W, $clog2(NSTG), width of one forwarding select.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs_i  in  NRD*REG_W  source register indices; port p at bits [p*REG_W +: REG_W].
- id_rs_used_i  in  NRD  port p actually reads its register.
- id_wr_i  in  1  ID instruction writes a register.
- id_rd_i  in  REG_W  destination index.
- id_rdy_i  in  SEL_W  first slot in which the result is forwardable: 1 = ALU (ready in MEM), 2 = load (ready in WB).
- flush_i  in  1  squash the ID instruction this cycle.
- stall_o  out  1  hold IF/ID, insert a bubble into EX.
- ex_fwd_sel_o  out  NRD*SEL_W  per-port select for the instruction now in EX: 0 = register file, k = forward from slot k.
- sb_busy_o  out  1  any slot valid.

Behaviour:
- Reset: synchronous and active-high, sampled on the rising edge of clk. It clears every slot's valid bit and ex_fwd_sel_o to 0. Resulting outputs: stall_o = 0, sb_busy_o = 0.
- Reset mid-operation discards all tracking. No residual stall follows.
- Slot entry fields: valid, rd, rdy.
- Slots shift every cycle (slot i -> i+1); slot NSTG-1 retires.
- Slot 0 load, by condition:
  - advance (id_valid_i & ~stall_o & ~flush_i): loads {id_wr_i & (id_rd_i != 0), id_rd_i, id_rdy_i}.
  - Otherwise: loads a bubble (valid = 0).
- Hazard check per port p (only if id_valid_i & id_rs_used_i[p] & rs != 0):
  - Find the youngest valid slot s (lowest index) with rd == rs.
  - Next cycle that producer sits in slot s+1.
  - If s+1 < rdy: port hazard.
  - Else if s+1 <= NSTG-1: sel = s+1.
  - Else (s = NSTG-1): sel = 0. The register file is write-through, so the same-cycle WB write is visible to the ID read.
- Youngest match has strict priority. Older matches are ignored even if a younger one hazards.
- stall_o: OR of port hazards, gated by ~flush_i. It is combinational from the slots and ID inputs, with no registered delay.
- ex_fwd_sel_o:
  - On advance: registers the computed selects.
  - On stall, flush, or invalid ID: registers 0 (EX holds a bubble).
- Latency: hazard decision in the same cycle; select visible one cycle later.
- Simultaneous flush_i and hazard: flush wins. No stall; a bubble enters.
- rd = 0 is never tracked.
- id_rdy_i = 0 is treated as 1.
- id_rdy_i > NSTG-1: the producer always stalls until it reaches slot NSTG-1, then sel = 0.
- sb_busy_o: OR of slot valids.

Optional Feature:
- Macro FWD_PERF_CNT_EN.
- When defined, adds three outputs:
  - perf_stall_o[31:0]: counts cycles with stall_o = 1.
  - perf_fwd_o[31:0]: counts advances with any nonzero select.
  - perf_flush_o[31:0]: counts flush_i cycles.
- All three are cleared by reset and wrap on overflow.
- When undefined, no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Package fwd_pkg holds:
  - select encodings FWD_RF = 0, FWD_MEM = 1, FWD_WB = 2.
  - latency classes RDY_ALU = 1, RDY_LOAD = 2.
  - the slot entry typedef {valid, rd, rdy}.
- One sub-module, fwd_port_check: per-port priority comparator across slots. It returns hazard and sel; instantiate NRD times.

Test Plan:
- ALU chain: add x5 advances, next cycle ID reads rs0 = x5 (rdy = 1) -> stall_o = 0; the following cycle ex_fwd_sel_o[port0] = 1.
- Load-use: lw x7 (rdy = 2) advances, next cycle ID reads rs1 = x7 -> stall_o = 1 for exactly 1 cycle, then advance with ex_fwd_sel_o[port1] = 2.
- Priority: add x3 then sub x3 back-to-back, third instruction reads x3 -> sel = 1 from the younger sub, not 2.
- x0 / unused: ID reads rs0 = x0 with matching writer to x0, or id_rs_used_i = 0 against a live match -> stall_o = 0, sel = 0.
- Flush during hazard: load-use hazard with flush_i = 1 -> stall_o = 0, bubble into slot 0, ex_fwd_sel_o = 0 next cycle.
- Reset mid-stream: 3 valid slots, assert reset one cycle -> sb_busy_o = 0, ex_fwd_sel_o = 0; a dependent instruction immediately after gives stall_o = 0, sel = 0.
